fmuls: RTL and testbench



---
 rtl/fmuls_pkg.sv | 21 ++
 rtl/baugh_wooley_mul8.sv | 30 +++
 rtl/fmuls.sv | 57 +++++
 tb/tb_fmuls.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fmuls_pkg.sv
// Shared ALU multiply constants and the explicit ripple adder used by the
// multiply units.
package fmuls_pkg;
  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_W    = 2;

  function automatic logic [RESULT_W-1:0] rca(input logic [RESULT_W-1:0] a,
                                              input logic [RESULT_W-1:0] b);
    logic [RESULT_W-1:0] s;
    logic                c;
    c = 1'b0;
    for (int i = 0; i < RESULT_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction
endpackage

// File: rtl/baugh_wooley_mul8.sv
// Combinational 8x8 signed multiplier built from Baugh-Wooley partial products.
module baugh_wooley_mul8
  import fmuls_pkg::*;
(
  input  logic [OPERAND_W-1:0] i_a,
  input  logic [OPERAND_W-1:0] i_b,
  output logic [RESULT_W-1:0]  o_p
);
  logic [OPERAND_W:0][RESULT_W-1:0] w_row;
  logic [RESULT_W-1:0]              w_acc;

  always_comb begin
    w_row = '0;
    for (int j = 0; j < OPERAND_W; j++) begin
      for (int i = 0; i < OPERAND_W; i++) begin
        // Terms mixing exactly one sign bit carry negative weight: invert them.
        if ((i == OPERAND_W-1) != (j == OPERAND_W-1))
          w_row[j][i+j] = ~(i_a[i] & i_b[j]);
        else
          w_row[j][i+j] = i_a[i] & i_b[j];
      end
    end
    // Correction constant 2^8 + 2^15 for the inverted terms (mod 2^16).
    w_row[OPERAND_W][OPERAND_W]   = 1'b1;
    w_row[OPERAND_W][RESULT_W-1]  = 1'b1;
    w_acc = '0;
    for (int k = 0; k <= OPERAND_W; k++) w_acc = rca(w_acc, w_row[k]);
    o_p = w_acc;
  end
endmodule

// File: rtl/fmuls.sv
// Registered signed fractional multiply (AVR FMULS): 1.7 x 1.7 -> 1.15 with C/Z.
module fmuls
  import fmuls_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [OPERAND_W-1:0] i_rd,
  input  logic [OPERAND_W-1:0] i_rr,
  output logic [OPERAND_W-1:0] o_r1,
  output logic [OPERAND_W-1:0] o_r0,
  output logic                 o_c,
  output logic                 o_z,
  output logic                 o_valid
);
  logic [RESULT_W-1:0] w_p;
  logic [RESULT_W-1:0] w_res;
  logic [FLAG_W-1:0]   w_flags;
  logic [RESULT_W-1:0] r_res;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_valid;

  baugh_wooley_mul8 u_mul (
    .i_a (i_rd),
    .i_b (i_rr),
    .o_p (w_p)
  );

  // -1.0 x -1.0 wraps to -1.0 in 1.15; no saturation.
  assign w_res = {w_p[RESULT_W-2:0], 1'b0};

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_C] = w_p[RESULT_W-1];
    w_flags[FLAG_Z] = (w_res == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res   <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign o_r1    = r_res[RESULT_W-1:OPERAND_W];
  assign o_r0    = r_res[OPERAND_W-1:0];
  assign o_c     = r_flags[FLAG_C];
  assign o_z     = r_flags[FLAG_Z];
  assign o_valid = r_valid;
endmodule

// File: tb/tb_fmuls.sv
// Self-checking bench for fmuls: vector table, reset/hold sequences, exhaustive sweep.
module tb_fmuls;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_rd, i_rr;
  logic [7:0] o_r1, o_r0;
  logic       o_c, o_z, o_valid;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] rd, rr, r1, r0;
    logic       c, z;
  } vec_t;

  vec_t       tbl[10];
  logic [17:0] sb_q[$];
  logic       mon_en = 1'b0;

  fmuls dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_rd    (i_rd),
    .i_rr    (i_rr),
    .o_r1    (o_r1),
    .o_r0    (o_r0),
    .o_c     (o_c),
    .o_z     (o_z),
    .o_valid (o_valid)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ref_model(input logic [7:0] rd, input logic [7:0] rr);
    int          p;
    logic [15:0] pu, r;
    p  = int'($signed(rd)) * int'($signed(rr));
    pu = p[15:0];
    r  = {pu[14:0], 1'b0};
    return {r, pu[15], (r == 16'h0)};
  endfunction

  // Each result is valid for exactly one negedge; pop one expectation per result.
  always @(negedge i_clk) begin
    if (mon_en && o_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h%h with no pending operation", o_r1, o_r0);
      end else begin
        chk("result", {14'h0, o_r1, o_r0, o_c, o_z}, {14'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] rd, input logic [7:0] rr, input logic [17:0] exp);
    i_valid = 1'b1;
    i_rd    = rd;
    i_rr    = rr;
    sb_q.push_back(exp);
    step();
  endtask

  task automatic drain();
    i_valid = 1'b0;
    step();
    step();
    chk("queue_drained", sb_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{rd:8'h80, rr:8'h80, r1:8'h80, r0:8'h00, c:1'b0, z:1'b0};
    tbl[1] = '{rd:8'h80, rr:8'h00, r1:8'h00, r0:8'h00, c:1'b0, z:1'b1};
    tbl[2] = '{rd:8'h40, rr:8'h40, r1:8'h20, r0:8'h00, c:1'b0, z:1'b0};
    tbl[3] = '{rd:8'h01, rr:8'h01, r1:8'h00, r0:8'h02, c:1'b0, z:1'b0};
    tbl[4] = '{rd:8'h40, rr:8'hC0, r1:8'hE0, r0:8'h00, c:1'b1, z:1'b0};
    tbl[5] = '{rd:8'h7F, rr:8'h7F, r1:8'h7E, r0:8'h02, c:1'b0, z:1'b0};
    tbl[6] = '{rd:8'h80, rr:8'h7F, r1:8'h81, r0:8'h00, c:1'b1, z:1'b0};
    tbl[7] = '{rd:8'hFF, rr:8'hFF, r1:8'h00, r0:8'h02, c:1'b0, z:1'b0};
    tbl[8] = '{rd:8'hFF, rr:8'h01, r1:8'hFF, r0:8'hFE, c:1'b1, z:1'b0};
    tbl[9] = '{rd:8'h80, rr:8'h01, r1:8'hFF, r0:8'h00, c:1'b1, z:1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_rd = 8'h00; i_rr = 8'h00;
    step(); step();
    chk("reset_outputs", {o_r1, o_r0, o_c, o_z, o_valid}, 19'h0);
    i_rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Table vectors back-to-back.
    for (int k = 0; k < 10; k++)
      issue(tbl[k].rd, tbl[k].rr, {tbl[k].r1, tbl[k].r0, tbl[k].c, tbl[k].z});
    drain();

    // Hold: outputs keep the last result while i_valid is low.
    issue(8'h40, 8'hC0, {8'hE0, 8'h00, 1'b1, 1'b0});
    i_valid = 1'b0; i_rd = 8'h7F; i_rr = 8'h7F;
    step();
    chk("hold_valid_low", o_valid, 1'b0);
    step();
    chk("hold_values", {o_r1, o_r0, o_c, o_z}, {8'hE0, 8'h00, 1'b1, 1'b0});

    // Reset beats a simultaneous strobe; the operand is dropped.
    i_rst = 1'b1; i_valid = 1'b1; i_rd = 8'h40; i_rr = 8'h40;
    step();
    chk("rst_priority", {o_r1, o_r0, o_c, o_z, o_valid}, 19'h0);
    i_rst = 1'b0; i_valid = 1'b0;
    step();
    chk("after_rst_hold", {o_r1, o_r0, o_c, o_z, o_valid}, 19'h0);

    // Reset right after an issue discards the in-flight result.
    mon_en = 1'b0;
    i_valid = 1'b1; i_rd = 8'h7F; i_rr = 8'h7F;
    step();
    chk("inflight_valid", {o_r1, o_valid}, {8'h7E, 1'b1});
    i_rst = 1'b1; i_valid = 1'b0;
    step();
    chk("inflight_discard", {o_r1, o_r0, o_c, o_z, o_valid}, 19'h0);
    i_rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        issue(a[7:0], b[7:0], ref_model(a[7:0], b[7:0]));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
